// File: rtl/rs232_pkg.sv
// rs232_pkg
//   Shared definitions for the RS-232 receive path: receiver FSM states,
//   default line/clock parameters, derived divider and mid-bit index, and
//   helper functions for flit sizing and divider calculation.
//   No ports (package).
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int DEF_BAUD       = 115_200;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_FLIT_BYTES = 4;

  localparam int DIV        = DEF_CLK_HZ / (DEF_BAUD * DEF_OVERSAMPLE);
  localparam int MID_SAMPLE = DEF_OVERSAMPLE / 2 - 1;

  // Width in bits of a flit built from nBytes serial bytes.
  function automatic int flitWidth(input int nBytes);
    return 8 * nBytes;
  endfunction

  // Clock cycles per oversample tick, truncated toward zero.
  function automatic int calcDiv(input int clkHz, input int baud, input int overSample);
    return clkHz / (baud * overSample);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1 serial byte receiver with oversampling.
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous active-high reset
//     rxSerial_i   raw serial line, idle high, asynchronous to clk
//     byteData_o   last good byte received
//     byteValid_o  one-cycle pulse when byteData_o holds a new good byte
//     frameErr_o   one-cycle pulse when the stop bit was sampled low
//     busy_o       high whenever the receiver is not idle
module uart_rx_core
  import rs232_pkg::*;
#(
  parameter int DIVISOR    = DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int MID_IDX    = MID_SAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxSerial_i,
  output logic [7:0] byteData_o,
  output logic       byteValid_o,
  output logic       frameErr_o,
  output logic       busy_o
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int SMP_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [SMP_W-1:0] SMP_MID   = SMP_W'(MID_IDX);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);

  logic             sync1_q, sync2_q, sync3_q;
  logic [CNT_W-1:0] tickCnt_q;
  logic [SMP_W-1:0] sampleCnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       byteData_q;
  logic             byteValid_q;
  logic             frameErr_q;
  rx_state_t        state_q;

  logic rxSync;
  logic fallEdge;
  logic tick;

  assign rxSync   = sync2_q;
  assign fallEdge = sync3_q & ~sync2_q;
  assign tick     = (state_q != IDLE) && (tickCnt_q == TICK_LAST);

  // Two flops tame metastability on the asynchronous line; the third keeps
  // the previous synced value so a high-to-low transition can be spotted.
  // All three reset to the idle (high) level so reset never fakes a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rxSerial_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Oversample tick generator. It is held at zero while idle so the first
  // tick after a start-bit detect lands a full tick period later, keeping
  // the mid-bit sample aligned to the detected edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickCnt_q <= '0;
    end else if (state_q == IDLE || tick) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + CNT_W'(1);
    end
  end

  // Receiver FSM. The start bit is checked at its middle to reject short
  // glitches; every later bit is sampled one full bit period after the
  // previous sample, which keeps each sample near its bit centre. A low stop
  // bit parks the FSM in BREAK until the line returns high, so a held-low
  // line cannot be misread as a stream of start bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      byteData_q  <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fallEdge) begin
            state_q     <= START;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (sampleCnt_q == SMP_MID) begin
              sampleCnt_q <= '0;
              state_q     <= rxSync ? IDLE : DATA;
            end else begin
              sampleCnt_q <= sampleCnt_q + SMP_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sampleCnt_q == SMP_LAST) begin
              shift_q     <= {rxSync, shift_q[7:1]};
              sampleCnt_q <= '0;
              bitCnt_q    <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                state_q <= STOP;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + SMP_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sampleCnt_q == SMP_LAST) begin
              sampleCnt_q <= '0;
              if (rxSync) begin
                byteData_q  <= shift_q;
                byteValid_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                frameErr_q <= 1'b1;
                state_q    <= BREAK;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + SMP_W'(1);
            end
          end
        end
        BREAK: begin
          if (rxSync) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byteData_o  = byteData_q;
  assign byteValid_o = byteValid_q;
  assign frameErr_o  = frameErr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: rtl/rs232_rx_flit.sv
// rs232_rx_flit
//   RS-232 receive front end: recovers 8N1 bytes, packs FLIT_BYTES of them
//   (first byte in the lowest lane) into one flit and offers it on a
//   valid/ready interface.
//   Ports:
//     clk          system clock, rising edge
//     reset        asynchronous active-high reset
//     Rs232_Rx     serial line, idle high
//     flit_data    assembled flit, stable while flit_valid is high
//     flit_valid   flit_data holds an unaccepted flit
//     flit_ready   consumer accepts on a clock edge with flit_valid high
//     frame_err    one-cycle pulse on a low stop bit
//     overrun_err  one-cycle pulse when a finished flit is dropped
//     rx_busy      receiver is inside a frame or waiting out a break
module rs232_rx_flit
  import rs232_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int FLIT_BYTES = DEF_FLIT_BYTES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             Rs232_Rx,
  output logic [flitWidth(FLIT_BYTES)-1:0] flit_data,
  output logic                             flit_valid,
  input  logic                             flit_ready,
  output logic                             frame_err,
  output logic                             overrun_err,
  output logic                             rx_busy
);

  localparam int FLIT_W = flitWidth(FLIT_BYTES);
  localparam int IDX_W  = (FLIT_BYTES > 1) ? $clog2(FLIT_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FLIT_BYTES - 1);

  logic [7:0] byteData;
  logic       byteValid;
  logic       coreFrameErr;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FLIT_W-1:0] assembly_q, assembly_d;
  logic [FLIT_W-1:0] flitData_q, flitData_d;
  logic              flitValid_q, flitValid_d;
  logic              overrun_q, overrun_d;

  uart_rx_core #(
    .DIVISOR    (calcDiv(CLK_HZ, BAUD, OVERSAMPLE)),
    .OVERSAMPLE (OVERSAMPLE),
    .MID_IDX    (OVERSAMPLE / 2 - 1)
  ) uCore (
    .clk         (clk),
    .reset       (reset),
    .rxSerial_i  (Rs232_Rx),
    .byteData_o  (byteData),
    .byteValid_o (byteValid),
    .frameErr_o  (coreFrameErr),
    .busy_o      (rx_busy)
  );

  // Flit assembly and output handshake. A framing error throws away the
  // partly built flit so the next good byte starts again at lane 0. A
  // finished flit may take the output slot if it is empty or being accepted
  // on this very edge; otherwise the new flit is dropped and the held one is
  // left untouched.
  always_comb begin
    idx_d       = idx_q;
    assembly_d  = assembly_q;
    flitData_d  = flitData_q;
    flitValid_d = flitValid_q;
    overrun_d   = 1'b0;

    if (flitValid_q && flit_ready) begin
      flitValid_d = 1'b0;
    end

    if (coreFrameErr) begin
      idx_d = '0;
    end else if (byteValid) begin
      assembly_d[idx_q*8 +: 8] = byteData;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (!flitValid_q || flit_ready) begin
          flitData_d  = assembly_d;
          flitValid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State registers for the assembler and output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      assembly_q  <= '0;
      flitData_q  <= '0;
      flitValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      assembly_q  <= assembly_d;
      flitData_q  <= flitData_d;
      flitValid_q <= flitValid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign flit_data   = flitData_q;
  assign flit_valid  = flitValid_q;
  assign overrun_err = overrun_q;
  assign frame_err   = coreFrameErr;

endmodule

// File: tb/tb_rs232_rx_flit.sv
// tb_rs232_rx_flit
//   Directed bench for rs232_rx_flit. A bus-functional model drives 8N1
//   frames; a monitor counts handshakes and error pulses. The line runs at
//   a faster baud (divider 4, 64 clocks per bit) so frame timing is the same
//   shape with far fewer cycles.
module tb_rs232_rx_flit;

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        Rs232_Rx;
  logic        flit_ready;
  logic [31:0] flit_data;
  logic        flit_valid;
  logic        frame_err;
  logic        overrun_err;
  logic        rx_busy;

  int checks = 0;
  int failures = 0;

  int xferCount = 0;
  int frameCount = 0;
  int overrunCount = 0;
  int validCycles = 0;
  logic [31:0] xferQ[$];
  logic        prevValid = 1'b0;
  logic [31:0] prevData = '0;

  int x0, f0, o0, v0;
  bit timedOut;

  rs232_rx_flit #(
    .CLK_HZ     (50_000_000),
    .BAUD       (781_250),
    .OVERSAMPLE (16),
    .FLIT_BYTES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs232_Rx    (Rs232_Rx),
    .flit_data   (flit_data),
    .flit_valid  (flit_valid),
    .flit_ready  (flit_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  // Drives one 8N1 frame, LSB first. The line is left at the stop-bit level
  // so a low stop bit can be stretched into a break by the caller.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
    @(negedge clk);
    Rs232_Rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rs232_Rx = value[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    Rs232_Rx = stopBit;
    repeat (BIT_CLKS) @(negedge clk);
    repeat (10) @(negedge clk);
  endtask

  // Waits for rx_busy to rise and then fall, with a cycle budget.
  task automatic waitBusyFall(output bit expired);
    int n;
    n = 0;
    expired = 1'b0;
    while (!rx_busy) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        expired = 1'b1;
        return;
      end
    end
    while (rx_busy) begin
      @(negedge clk);
      n++;
      if (n > 12 * BIT_CLKS) begin
        expired = 1'b1;
        return;
      end
    end
  endtask

  function automatic logic [31:0] lastXfer();
    if (xferQ.size() == 0) return 32'hDEAD_0000;
    return xferQ[xferQ.size()-1];
  endfunction

  task automatic snapshot();
    x0 = xferCount;
    f0 = frameCount;
    o0 = overrunCount;
    v0 = validCycles;
  endtask

  // Monitor, one sample per cycle just after the rising edge. A handshake
  // happened on that edge if valid was high before it and ready was high.
  // While a flit sits unaccepted its data must not move.
  always begin
    @(posedge clk);
    #1;
    if (prevValid && flit_ready) begin
      xferCount++;
      xferQ.push_back(prevData);
    end
    if (prevValid && flit_valid && !flit_ready) begin
      checkOutput("hold_stable", flit_data, prevData);
    end
    if (frame_err) frameCount++;
    if (overrun_err) overrunCount++;
    if (flit_valid) validCycles++;
    prevValid = flit_valid;
    prevData  = flit_data;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    Rs232_Rx   = 1'b1;
    flit_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", {31'b0, flit_valid}, 32'd0);
    checkOutput("rst_data", flit_data, 32'd0);
    checkOutput("rst_busy", {31'b0, rx_busy}, 32'd0);
    checkOutput("rst_ferr", {31'b0, frame_err}, 32'd0);
    checkOutput("rst_oerr", {31'b0, overrun_err}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] test 1: basic flit with ready high");
    flit_ready = 1'b1;
    snapshot();
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    fork
      applyStimulus(8'h44, 1'b1);
      begin
        waitBusyFall(timedOut);
        checkOutput("t1_wait", {31'b0, timedOut}, 32'd0);
        checkOutput("t1_valid_pre", {31'b0, flit_valid}, 32'd0);
        @(negedge clk);
        checkOutput("t1_valid_lat", {31'b0, flit_valid}, 32'd1);
        checkOutput("t1_data", flit_data, 32'h44332211);
      end
    join
    repeat (10) @(negedge clk);
    checkOutput("t1_xfers", xferCount - x0, 32'd1);
    checkOutput("t1_xdata", lastXfer(), 32'h44332211);
    checkOutput("t1_vcycles", validCycles - v0, 32'd1);
    checkOutput("t1_ferr", frameCount - f0, 32'd0);
    checkOutput("t1_oerr", overrunCount - o0, 32'd0);

    $display("[TB] test 2: short low glitch");
    snapshot();
    @(negedge clk);
    Rs232_Rx = 1'b0;
    repeat (12) @(negedge clk);
    Rs232_Rx = 1'b1;
    checkOutput("t2_busy_hi", {31'b0, rx_busy}, 32'd1);
    repeat (60) @(negedge clk);
    checkOutput("t2_busy_lo", {31'b0, rx_busy}, 32'd0);
    checkOutput("t2_ferr", frameCount - f0, 32'd0);
    checkOutput("t2_noxfer", xferCount - x0, 32'd0);
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h0F, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("t2_xfers", xferCount - x0, 32'd1);
    checkOutput("t2_xdata", lastXfer(), 32'hF00F5AC3);

    $display("[TB] test 3: framing error and break");
    snapshot();
    applyStimulus(8'h99, 1'b1);
    applyStimulus(8'hA5, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("t3_busy_brk", {31'b0, rx_busy}, 32'd1);
    checkOutput("t3_ferr", frameCount - f0, 32'd1);
    Rs232_Rx = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t3_busy_lo", {31'b0, rx_busy}, 32'd0);
    checkOutput("t3_noxfer", xferCount - x0, 32'd0);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h04, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("t3_xfers", xferCount - x0, 32'd1);
    checkOutput("t3_xdata", lastXfer(), 32'h04030201);
    checkOutput("t3_ferr_once", frameCount - f0, 32'd1);

    $display("[TB] test 4: overrun with ready low");
    flit_ready = 1'b0;
    snapshot();
    for (int b = 0; b < 8; b++) begin
      applyStimulus(8'h10 + 8'(b), 1'b1);
    end
    repeat (10) @(negedge clk);
    checkOutput("t4_valid", {31'b0, flit_valid}, 32'd1);
    checkOutput("t4_data", flit_data, 32'h13121110);
    checkOutput("t4_oerr", overrunCount - o0, 32'd1);
    checkOutput("t4_noxfer", xferCount - x0, 32'd0);
    flit_ready = 1'b1;
    repeat (5) @(negedge clk);
    flit_ready = 1'b0;
    checkOutput("t4_xfers", xferCount - x0, 32'd1);
    checkOutput("t4_xdata", lastXfer(), 32'h13121110);
    checkOutput("t4_valid_lo", {31'b0, flit_valid}, 32'd0);

    $display("[TB] test 5: reset in the middle of a byte");
    applyStimulus(8'h21, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h23, 1'b1);
    applyStimulus(8'h24, 1'b1);
    applyStimulus(8'h55, 1'b1);
    @(negedge clk);
    Rs232_Rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      Rs232_Rx = i[0];
      repeat (BIT_CLKS) @(negedge clk);
    end
    repeat (BIT_CLKS / 2) @(negedge clk);
    checkOutput("t5_valid_pre", {31'b0, flit_valid}, 32'd1);
    checkOutput("t5_busy_pre", {31'b0, rx_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_valid_rst", {31'b0, flit_valid}, 32'd0);
    checkOutput("t5_busy_rst", {31'b0, rx_busy}, 32'd0);
    checkOutput("t5_data_rst", flit_data, 32'd0);
    Rs232_Rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    flit_ready = 1'b1;
    snapshot();
    applyStimulus(8'hDE, 1'b1);
    applyStimulus(8'hAD, 1'b1);
    applyStimulus(8'hBE, 1'b1);
    applyStimulus(8'hEF, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("t5_xfers", xferCount - x0, 32'd1);
    checkOutput("t5_xdata", lastXfer(), 32'hEFBEADDE);

    $display("[TB] test 6: drain and reload on the same edge");
    flit_ready = 1'b0;
    snapshot();
    applyStimulus(8'h31, 1'b1);
    applyStimulus(8'h32, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h42, 1'b1);
    applyStimulus(8'h43, 1'b1);
    fork
      applyStimulus(8'h44, 1'b1);
      begin
        waitBusyFall(timedOut);
        checkOutput("t6_wait", {31'b0, timedOut}, 32'd0);
        flit_ready = 1'b1;
        @(negedge clk);
        flit_ready = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    checkOutput("t6_xfers1", xferCount - x0, 32'd1);
    checkOutput("t6_xdata1", lastXfer(), 32'h34333231);
    checkOutput("t6_valid", {31'b0, flit_valid}, 32'd1);
    checkOutput("t6_data", flit_data, 32'h44434241);
    checkOutput("t6_oerr", overrunCount - o0, 32'd0);
    flit_ready = 1'b1;
    repeat (5) @(negedge clk);
    flit_ready = 1'b0;
    checkOutput("t6_xfers2", xferCount - x0, 32'd2);
    checkOutput("t6_xdata2", lastXfer(), 32'h44434241);
    checkOutput("t6_valid_lo", {31'b0, flit_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
